pipe_feed: RTL
==============

PIPE_FEED -- requirements
Module: pipe_feed

Interface
REQ-001 Parameter N, default 10: operand and result width in bits.
REQ-002 Parameter IDEPTH, default 4: input tuple FIFO depth, power of two.
REQ-003 Parameter RDEPTH, default 8: result FIFO depth, power of two, SHALL be >= LAT+2.
REQ-004 Parameter LAT, default 3: register latency of the attached arithmetic pipe, pipe_f valid after LAT edges from sampling op_*.
REQ-005 clk  input  1  single clock; all state on posedge clk.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  upstream offers a tuple.
REQ-008 in_ready  output  1  block accepts the tuple this cycle.
REQ-009 in_a, in_b, in_c, in_d  input  N each  operand tuple.
REQ-010 op_a, op_b, op_c, op_d  output  N each  registered operands driven to the pipe.
REQ-011 pipe_f  input  N  pipe result, computing (a+b)+(c-d) times d, mod 2^N.
REQ-012 out_valid  output  1  result FIFO head valid.
REQ-013 out_ready  input  1  downstream accepts the head.
REQ-014 out_f  output  N  result FIFO head value.
REQ-015 busy  output  1  high when any FIFO is non-empty or any issued tuple is in flight.

Function
REQ-016 Accept: push on in_valid && in_ready; in_ready SHALL equal input FIFO not full, with no same-cycle pop-through when full.
REQ-017 Issue: one tuple per cycle when the input FIFO is non-empty and credit > 0; op_* load the head on that edge, and the head is popped.
REQ-018 Credit SHALL equal RDEPTH - result_count - inflight, both sampled before the edge; a same-cycle output pop SHALL NOT add credit.
REQ-019 Without issue, op_* SHALL hold their previous values; pipe output for non-issued cycles is never captured.
REQ-020 Tag line: a 1-bit shift register of LAT+1 stages SHALL mark issues; a tuple loaded into op_* at edge k SHALL be written into the result FIFO from pipe_f at edge k+LAT+1.
REQ-021 inflight counter SHALL increment on issue, decrement on capture, and be unchanged when both occur; range 0..LAT+1.
REQ-022 Result FIFO: out_valid = non-empty, out_f = head, pop on out_valid && out_ready; simultaneous capture and pop SHALL leave the count unchanged.
REQ-023 Result overflow SHALL be impossible by the credit rule.
REQ-024 Ordering: results SHALL leave in acceptance order.
REQ-025 Latency from an empty block: tuple accepted at edge t SHALL raise out_valid after edge t+LAT+2.
REQ-026 Throughput: with out_ready held high, one result per cycle sustained.
REQ-027 Arithmetic: no width changes; out_f is pipe_f bit-exact (mod 2^N wrap).

Reset
REQ-028 rst high SHALL immediately clear both FIFOs, the tag line and inflight, and force op_*=0, in_ready=0, out_valid=0, out_f=0, busy=0.
REQ-029 Reset mid-operation SHALL discard in-flight tuples; no stale pipe_f SHALL be captured after release.
REQ-030 in_ready SHALL rise on the first clk edge after rst deasserts.

Structure
REQ-031 A shared package SHALL hold the defaults N=10 and LAT=3, used by pipe_feed and the pipe.
REQ-032 One sub-module, sync_fifo (parameters WIDTH and DEPTH, with count output), SHALL be instantiated twice: for the 4N-bit tuples and for the N-bit results.

Verification
REQ-033 Test 1: a=3, b=4, c=10, d=2, out_ready=1 -> out_f=30; out_valid rises after edge t+5.
REQ-034 Test 2: (1023,1,0,0) -> 0, then (0,0,0,1) -> 1023, and (0,0,600,2) -> 172, in order.
REQ-035 Test 3: out_ready=0, 12 tuples offered -> at most RDEPTH+IDEPTH accepted, then in_ready=0; no loss; release gives in-order output.
REQ-036 Test 4: back-to-back stream of 20 tuples with out_ready=1 -> 20 results on consecutive cycles after the initial latency.
REQ-037 Test 5: rst pulsed with 3 tuples in flight -> out_valid=0 and busy=0 immediately; the next tuple after release gives only its own result.
REQ-038 Test 6: random out_ready toggling on 200 tuples -> scoreboard match, inflight never exceeds LAT+1.

Source files
------------

// File: rtl/pipe_feed_pkg.sv
// rtl/pipe_feed_pkg.sv - shared defaults and reference arithmetic for the feed and its pipe
package pipe_feed_pkg;

    // Operand/result width and pipe register latency shared by the feed and the pipe.
    localparam int DEF_N      = 10;
    localparam int DEF_LAT    = 3;
    localparam int DEF_IDEPTH = 4;
    localparam int DEF_RDEPTH = 8;

    typedef logic [DEF_N-1:0] word_t;

    // Function of the attached arithmetic pipe: ((a+b)+(c-d))*d, wrapping at DEF_N bits.
    function automatic word_t pipe_calc(input word_t a, input word_t b,
                                        input word_t c, input word_t d);
        word_t s;
        s = (a + b) + (c - d);
        return s * d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO or a pop from an empty one is ignored.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; entries are only visible once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pipe_feed.sv
// rtl/pipe_feed.sv - credit-based feeder around a fixed-latency arithmetic pipe
module pipe_feed
    import pipe_feed_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int IDEPTH = DEF_IDEPTH,
    parameter int RDEPTH = DEF_RDEPTH,
    parameter int LAT    = DEF_LAT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_c,
    input  logic [N-1:0] in_d,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    output logic [N-1:0] op_c,
    output logic [N-1:0] op_d,
    input  logic [N-1:0] pipe_f,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_f,
    output logic         busy
);

    localparam int TW  = 4 * N;
    localparam int ICW = $clog2(IDEPTH + 1);
    localparam int RCW = $clog2(RDEPTH + 1);
    localparam int FW  = $clog2(LAT + 2);
    localparam int UW  = $clog2(RDEPTH + LAT + 2) + 1;

    logic [TW-1:0]  in_head;
    logic [ICW-1:0] in_count;
    logic           in_empty;
    logic           in_full;
    logic           in_push;
    logic           ready_en;

    logic [UW-1:0]  used;
    logic           issue;
    logic [LAT:0]   tag;
    logic           capture;
    logic [FW-1:0]  inflight;

    logic [N-1:0]   res_head;
    logic [RCW-1:0] res_count;
    logic           res_empty;
    logic           out_pop;

    // Input side: ready is held low until the first edge after reset release.
    assign in_empty = (in_count == '0);
    assign in_full  = (in_count == ICW'(IDEPTH));
    assign in_ready = ready_en && !in_full;
    assign in_push  = in_valid && in_ready;

    // Result slots already claimed, either stored or still travelling down the pipe.
    // A pop this cycle does not free a slot until the next cycle.
    assign used    = UW'(res_count) + UW'(inflight);
    assign issue   = !in_empty && (used < UW'(RDEPTH));
    assign capture = tag[LAT];

    assign res_empty = (res_count == '0);
    assign out_valid = !res_empty;
    assign out_pop   = out_valid && out_ready;
    // Head is masked while empty so stale storage never appears on out_f.
    assign out_f     = out_valid ? res_head : '0;

    assign busy = !in_empty || !res_empty || (inflight != '0);

    sync_fifo #(
        .WIDTH (TW),
        .DEPTH (IDEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_push),
        .push_data ({in_a, in_b, in_c, in_d}),
        .pop       (issue),
        .head      (in_head),
        .count     (in_count)
    );

    sync_fifo #(
        .WIDTH (N),
        .DEPTH (RDEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (pipe_f),
        .pop       (out_pop),
        .head      (res_head),
        .count     (res_count)
    );

    // Ready enable: rises on the first clock edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_en <= 1'b0;
        else     ready_en <= 1'b1;
    end

    // Operand registers load the input head on issue and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
            op_c <= '0;
            op_d <= '0;
        end else if (issue) begin
            {op_a, op_b, op_c, op_d} <= in_head;
        end
    end

    // Tag line: an issue at edge k reaches the top stage at edge k+LAT, so the
    // result is captured at edge k+LAT+1 when pipe_f carries that tuple.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tag <= '0;
        else     tag <= {tag[LAT-1:0], issue};
    end

    // In-flight count of issued tuples not yet captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, capture})
                2'b10:   inflight <= inflight + FW'(1);
                2'b01:   inflight <= inflight - FW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule
